timebase_counter: RTL and testbench

- Parametrised modulo up/down counter; generalises the audio path's free-running 17-bit counter.
- Adds enable, clear, parallel load, runtime modulus, direction control, a terminal-count pulse, a divided square-wave output and a saturating wrap counter.
- Sits in the audio clocking path and generates sample-rate, bit-clock and LR-clock timebases from the system clock.

---
 rtl/timebase_counter.sv | 118 +++++++++++
 tb/tb_timebase_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timebase_counter.sv
// ---------------------------------------------------------------------------
// timebase_counter
//
// Modulo up/down counter for the audio clocking path. It derives
// sample-rate, bit-clock and LR-clock timebases from the system clock.
// The modulus can be changed at run time. The counter also produces a
// terminal-count pulse, a divide-by-2*modulus square wave and a saturating
// count of wraps.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high; clears every output
//   en           count enable
//   clr          synchronous clear of the count (div_out/wrap_cnt hold)
//   load         parallel load strobe
//   load_val     value taken on load (not clipped to the modulus)
//   dir          0 = count up, 1 = count down
//   mod_val      modulus; 0 means 2^WIDTH
//   counter_out  current count (registered)
//   tc           high in the cycle the post-wrap value is visible
//   div_out      toggles on every wrap
//   wrap_cnt     number of wraps, saturating at all-ones
//
// Priority on each edge: reset > clr > load > en.
// ---------------------------------------------------------------------------
module timebase_counter #(
    parameter int WIDTH  = 17,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              dir,
    input  logic [WIDTH-1:0]  mod_val,
    output logic [WIDTH-1:0]  counter_out,
    output logic              tc,
    output logic              div_out,
    output logic [WRAP_W-1:0] wrap_cnt
);

    logic [WIDTH-1:0]  r_cnt;
    logic              r_tc;
    logic              r_div;
    logic [WRAP_W-1:0] r_wrap_cnt;

    // top is formed in WIDTH+1 bits so that mod_val=0 (2^WIDTH) does not
    // underflow. Its MSB is always zero.
    logic [WIDTH:0]    w_top_ext;
    logic [WIDTH-1:0]  w_next_cnt;
    logic              w_wrap;

    always_comb begin
        if (mod_val == '0) begin
            w_top_ext = {1'b0, {WIDTH{1'b1}}};
        end else begin
            w_top_ext = {1'b0, mod_val} - {{WIDTH{1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_next_cnt = r_cnt;
        w_wrap     = 1'b0;
        if (!dir) begin
            // >= rather than == so that an out-of-range count wraps
            // immediately. An out-of-range count comes from a load or a
            // shrinking modulus.
            if ({1'b0, r_cnt} >= w_top_ext) begin
                w_next_cnt = '0;
                w_wrap     = 1'b1;
            end else begin
                w_next_cnt = r_cnt + 1'b1;
            end
        end else begin
            // An out-of-range count simply decrements until it reaches 0.
            if (r_cnt == '0) begin
                w_next_cnt = w_top_ext[WIDTH-1:0];
                w_wrap     = 1'b1;
            end else begin
                w_next_cnt = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_tc       <= 1'b0;
            r_div      <= 1'b0;
            r_wrap_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else if (load) begin
            r_cnt <= load_val;
            r_tc  <= 1'b0;
        end else if (en) begin
            r_cnt <= w_next_cnt;
            r_tc  <= w_wrap;
            if (w_wrap) begin
                r_div <= ~r_div;
                if (r_wrap_cnt != {WRAP_W{1'b1}}) begin
                    r_wrap_cnt <= r_wrap_cnt + 1'b1;
                end
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign counter_out = r_cnt;
    assign tc          = r_tc;
    assign div_out     = r_div;
    assign wrap_cnt    = r_wrap_cnt;

endmodule

// File: tb/tb_timebase_counter.sv
// ---------------------------------------------------------------------------
// Bench for timebase_counter: directed steps followed by random traffic.
// Expected outputs come from an arithmetic reference model. Each expected
// output is pushed into a queue before the clock edge and popped and
// compared after the edge.
// ---------------------------------------------------------------------------
module tb_timebase_counter;

    localparam int WIDTH  = 17;
    localparam int WRAP_W = 8;
    localparam int EW     = WIDTH + 2 + WRAP_W;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              clr;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              dir;
    logic [WIDTH-1:0]  mod_val;
    logic [WIDTH-1:0]  counter_out;
    logic              tc;
    logic              div_out;
    logic [WRAP_W-1:0] wrap_cnt;

    always #5 clk = ~clk;

    timebase_counter #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .clr         (clr),
        .load        (load),
        .load_val    (load_val),
        .dir         (dir),
        .mod_val     (mod_val),
        .counter_out (counter_out),
        .tc          (tc),
        .div_out     (div_out),
        .wrap_cnt    (wrap_cnt)
    );

    // ---------------- reference model ----------------
    longint m_cnt   = 0;
    int     m_tc    = 0;
    int     m_div   = 0;
    int     m_wraps = 0;

    logic [EW-1:0] exp_q[$];

    int tests = 0;
    int fails = 0;

    task automatic model_edge(input logic rst, input logic e, input logic c,
                              input logic ld, input longint lv, input logic d,
                              input longint mv);
        longint top;
        int     wrapped;
        if (mv == 0) top = (longint'(1) << WIDTH) - 1;
        else         top = mv - 1;
        wrapped = 0;
        if (rst) begin
            m_cnt = 0; m_tc = 0; m_div = 0; m_wraps = 0;
        end else if (c) begin
            m_cnt = 0; m_tc = 0;
        end else if (ld) begin
            m_cnt = lv; m_tc = 0;
        end else if (e) begin
            if (!d) begin
                if (m_cnt >= top) begin m_cnt = 0; wrapped = 1; end
                else m_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin m_cnt = top; wrapped = 1; end
                else m_cnt = m_cnt - 1;
            end
            m_tc = wrapped;
            if (wrapped != 0) begin
                m_div   = 1 - m_div;
                m_wraps = (m_wraps >= 255) ? 255 : m_wraps + 1;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one edge's inputs, pushes the expectation, and checks after the edge.
    task automatic step(input logic rst, input logic e, input logic c,
                        input logic ld, input longint lv, input logic d,
                        input longint mv);
        logic [EW-1:0] exp_word;
        logic [EW-1:0] got;
        reset    = rst;
        en       = e;
        clr      = c;
        load     = ld;
        load_val = lv[WIDTH-1:0];
        dir      = d;
        mod_val  = mv[WIDTH-1:0];
        model_edge(rst, e, c, ld, longint'(lv[WIDTH-1:0]), d, longint'(mv[WIDTH-1:0]));
        exp_q.push_back({m_cnt[WIDTH-1:0], m_tc[0], m_div[0], m_wraps[WRAP_W-1:0]});
        @(posedge clk);
        #1;
        exp_word = exp_q.pop_front();
        got      = {counter_out, tc, div_out, wrap_cnt};
        check_val("counter_out", longint'(got[EW-1 -: WIDTH]), longint'(exp_word[EW-1 -: WIDTH]));
        check_val("tc",          longint'(got[WRAP_W+1]),      longint'(exp_word[WRAP_W+1]));
        check_val("div_out",     longint'(got[WRAP_W]),        longint'(exp_word[WRAP_W]));
        check_val("wrap_cnt",    longint'(got[WRAP_W-1:0]),    longint'(exp_word[WRAP_W-1:0]));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0;
        load_val = '0; dir = 1'b0; mod_val = '0;
        #1;

        // Reset for two cycles.
        step(1, 0, 0, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 0, 5);
        check_val("reset_cnt",  longint'(counter_out), 0);
        check_val("reset_wrap", longint'(wrap_cnt), 0);

        // Free run up, modulo 5, for 20 cycles.
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 5);
        check_val("free_cnt",  longint'(counter_out), 0);
        check_val("free_wrap", longint'(wrap_cnt), 4);
        check_val("free_div",  longint'(div_out), 0);

        // Down count modulo 4, starting from 0: 3,2,1,0,3.
        step(0, 1, 1, 0, 0, 1, 4);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, 4);
        check_val("down_cnt", longint'(counter_out), 3);
        check_val("down_tc",  longint'(tc), 1);

        // Load 9 counting down: 8..0 with no tc, then 3 with tc.
        step(0, 1, 0, 1, 9, 1, 4);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 1, 4);
        check_val("ld9_cnt", longint'(counter_out), 3);
        check_val("ld9_tc",  longint'(tc), 1);

        // clr beats load at count 3.
        step(0, 1, 0, 1, 3, 0, 5);
        step(0, 1, 1, 1, 5, 0, 5);
        check_val("clr_over_load", longint'(counter_out), 0);

        // Load beyond top, then wrap on the next enabled edge.
        step(0, 1, 0, 1, 7, 0, 5);
        check_val("ld7_cnt", longint'(counter_out), 7);
        step(0, 1, 0, 0, 0, 0, 5);
        check_val("ld7_wrap_cnt", longint'(counter_out), 0);
        check_val("ld7_wrap_tc",  longint'(tc), 1);

        // en low for 3 cycles: the count holds and tc stays 0.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 5);

        // Full range wrap.
        step(0, 1, 0, 1, 'h1FFFE, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check_val("full_max", longint'(counter_out), 'h1FFFF);
        step(0, 1, 0, 0, 0, 0, 0);
        check_val("full_zero", longint'(counter_out), 0);
        check_val("full_tc",   longint'(tc), 1);
        step(0, 1, 0, 0, 0, 0, 0);
        check_val("full_one", longint'(counter_out), 1);

        // Saturation: modulus 1 for 300 cycles.
        for (int i = 0; i < 300; i++) step(0, 1, 0, 0, 0, 0, 1);
        check_val("sat_wrap", longint'(wrap_cnt), 255);
        check_val("sat_tc",   longint'(tc), 1);

        // Reset in the middle of a count at 3.
        step(0, 1, 0, 1, 3, 0, 5);
        step(1, 1, 0, 0, 0, 0, 5);
        check_val("mid_rst_cnt", longint'(counter_out), 0);
        check_val("mid_rst_div", longint'(div_out), 0);
        step(0, 1, 0, 0, 0, 0, 5);
        step(0, 1, 0, 0, 0, 0, 5);
        check_val("resume_cnt", longint'(counter_out), 2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic   r_rst, r_en, r_clr, r_ld, r_dir;
            longint r_lv, r_mv;
            r_rst = ($urandom_range(0, 99) < 2);
            r_en  = ($urandom_range(0, 99) < 85);
            r_clr = ($urandom_range(0, 99) < 4);
            r_ld  = ($urandom_range(0, 99) < 6);
            r_dir = ($urandom_range(0, 99) < 40);
            r_lv  = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 'h1FFFF))
                                                : longint'($urandom_range(0, 24));
            r_mv  = ($urandom_range(0, 15) == 0) ? 0 : longint'($urandom_range(1, 12));
            step(r_rst, r_en, r_clr, r_ld, r_lv, r_dir, r_mv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
